usb_ctrl_ep0_responder: RTL and testbench

USB_CTRL_EP0_RESPONDER -- requirements
Module: usb_ctrl_ep0_responder

---
 rtl/usb_ctrl_ep0_responder_pkg.sv | 44 ++++
 rtl/usb_desc_rom.sv | 75 +++++++
 rtl/usb_ctrl_ep0_responder.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_usb_ctrl_ep0_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_ctrl_ep0_responder_pkg.sv
// Shared constants and types for the endpoint-0 control responder.
// Request codes, descriptor types, handshakes, token one-hots and FSM state encoding.
package usb_ctrl_ep0_responder_pkg;

  localparam logic [2:0] TXN_SETUP = 3'b100;
  localparam logic [2:0] TXN_OUT   = 3'b010;
  localparam logic [2:0] TXN_IN    = 3'b001;

  localparam logic [1:0] HSK_ACK   = 2'd0;
  localparam logic [1:0] HSK_NAK   = 2'd1;
  localparam logic [1:0] HSK_STALL = 2'd2;

  localparam logic [7:0] REQ_SET_ADDRESS       = 8'h05;
  localparam logic [7:0] REQ_GET_DESCRIPTOR    = 8'h06;
  localparam logic [7:0] REQ_GET_CONFIGURATION = 8'h08;
  localparam logic [7:0] REQ_SET_CONFIGURATION = 8'h09;

  localparam logic [7:0] DESC_DEVICE = 8'h01;
  localparam logic [7:0] DESC_CONFIG = 8'h02;
  localparam logic [7:0] DESC_STRING = 8'h03;

  // Standard requests addressed to the device recipient only.
  localparam logic [7:0] RT_HOST_TO_DEV = 8'h00;
  localparam logic [7:0] RT_DEV_TO_HOST = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA_IN,
    ST_STATUS_OUT,
    ST_STATUS_IN,
    ST_STALLED
  } ep0_state_e;

  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_SET_ADDR,
    ACT_SET_CFG
  } status_act_e;

  function automatic logic [15:0] min_u16(input logic [15:0] a, input logic [15:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/usb_desc_rom.sv
// Descriptor byte store: returns MAX_PKT bytes of the selected descriptor from a byte offset.
// Bytes past the end of a descriptor read as zero.
module usb_desc_rom
  import usb_ctrl_ep0_responder_pkg::*;
#(
  parameter int MAX_PKT      = 8,
  parameter int DEV_DESC_LEN = 18,
  parameter int CFG_DESC_LEN = 32
) (
  input  logic [7:0]           i_descType,
  input  logic [15:0]          i_offset,
  output logic [8*MAX_PKT-1:0] o_data
);

  function automatic logic [7:0] dev_byte(input logic [15:0] idx);
    logic [7:0] b;
    b = 8'h00;
    if (idx < 16'(DEV_DESC_LEN)) begin
      case (idx[4:0])
        5'd0:  b = 8'(DEV_DESC_LEN);
        5'd1:  b = DESC_DEVICE;
        5'd2:  b = 8'h00;  5'd3:  b = 8'h02;
        5'd4:  b = 8'h00;  5'd5:  b = 8'h00;  5'd6:  b = 8'h00;
        5'd7:  b = 8'(MAX_PKT);
        5'd8:  b = 8'h34;  5'd9:  b = 8'h12;
        5'd10: b = 8'h78;  5'd11: b = 8'h56;
        5'd12: b = 8'h00;  5'd13: b = 8'h01;
        5'd14: b = 8'h01;  5'd15: b = 8'h02;  5'd16: b = 8'h03;
        5'd17: b = 8'h01;
        default: b = 8'h00;
      endcase
    end else begin
      b = 8'h00;
    end
    return b;
  endfunction

  // Configuration, one vendor interface and a bulk IN/OUT endpoint pair.
  function automatic logic [7:0] cfg_byte(input logic [15:0] idx);
    logic [7:0] b;
    b = 8'h00;
    if (idx < 16'(CFG_DESC_LEN)) begin
      case (idx[4:0])
        5'd0:  b = 8'h09;  5'd1:  b = DESC_CONFIG;
        5'd2:  b = 8'(CFG_DESC_LEN);  5'd3: b = 8'(CFG_DESC_LEN >> 8);
        5'd4:  b = 8'h01;  5'd5:  b = 8'h01;  5'd6:  b = 8'h00;
        5'd7:  b = 8'h80;  5'd8:  b = 8'h32;
        5'd9:  b = 8'h09;  5'd10: b = 8'h04;  5'd11: b = 8'h00;
        5'd12: b = 8'h00;  5'd13: b = 8'h02;  5'd14: b = 8'hff;
        5'd15: b = 8'h00;  5'd16: b = 8'h00;  5'd17: b = 8'h00;
        5'd18: b = 8'h07;  5'd19: b = 8'h05;  5'd20: b = 8'h81;
        5'd21: b = 8'h02;  5'd22: b = 8'h40;  5'd23: b = 8'h00;  5'd24: b = 8'h00;
        5'd25: b = 8'h07;  5'd26: b = 8'h05;  5'd27: b = 8'h02;
        5'd28: b = 8'h02;  5'd29: b = 8'h40;  5'd30: b = 8'h00;  5'd31: b = 8'h00;
        default: b = 8'h00;
      endcase
    end else begin
      b = 8'h00;
    end
    return b;
  endfunction

  // Gather one packet-wide window starting at i_offset.
  always_comb begin
    o_data = '0;
    for (int i = 0; i < MAX_PKT; i++) begin
      case (i_descType)
        DESC_DEVICE: o_data[8*i +: 8] = dev_byte(i_offset + 16'(i));
        DESC_CONFIG: o_data[8*i +: 8] = cfg_byte(i_offset + 16'(i));
        default:     o_data[8*i +: 8] = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/usb_ctrl_ep0_responder.sv
// USB endpoint-0 control responder: SETUP decode, descriptor IN data stage, status stages, SET_ADDRESS.
// Define USB_CTRL_SETCONFIG_EN to add SET_CONFIGURATION / GET_CONFIGURATION support.
module usb_ctrl_ep0_responder
  import usb_ctrl_ep0_responder_pkg::*;
#(
  parameter int MAX_PKT      = 8,
  parameter int DEV_DESC_LEN = 18,
  parameter int CFG_DESC_LEN = 32
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_txnValid,
  output logic                         o_txnReady,
  input  logic [2:0]                   i_txnType,
  input  logic [8*MAX_PKT-1:0]         i_outData,
  input  logic [$clog2(MAX_PKT):0]     i_outData_nBytes,
  output logic                         o_rspValid,
  output logic [1:0]                   o_rspHsk,
  output logic [8*MAX_PKT-1:0]         o_inData,
  output logic [$clog2(MAX_PKT):0]     o_inData_nBytes,
  input  logic                         i_inAck,
  output logic [6:0]                   o_devAddr
);

  localparam int         NBW       = $clog2(MAX_PKT) + 1;
  localparam logic [15:0] MAX_PKT_W = 16'(MAX_PKT);

  ep0_state_e          state_q, state_d, state_a;
  status_act_e         act_q, act_d;
  logic [15:0]         offset_q, offset_d, offset_a;
  logic [15:0]         remaining_q, remaining_d, remaining_a;
  logic [15:0]         total_q, total_d, wlength_q, wlength_d;
  logic [7:0]          desc_type_q, desc_type_d, wvalue_q, wvalue_d;
  logic                src_cfg_q, src_cfg_d;
  logic                last_in_ack_q, last_in_ack_d, last_ack_a;
  logic [6:0]          dev_addr_q, dev_addr_d;
  logic                txn_ready_q, txn_ready_d, rsp_valid_q, rsp_valid_d;
  logic [1:0]          rsp_hsk_q, rsp_hsk_d;
  logic [8*MAX_PKT-1:0] in_data_q, in_data_d, rom_data_s;
  logic [NBW-1:0]      in_nbytes_q, in_nbytes_d;
`ifdef USB_CTRL_SETCONFIG_EN
  logic [7:0]          cfg_q, cfg_d;
`endif

  logic                accept_s;
  logic [7:0]          setup_bm_s, setup_breq_s;
  logic [15:0]         setup_wval_s, setup_wlen_s, desc_len_s, sent_s, pkt_len_s;
  logic                unused_s;

  assign setup_bm_s   = i_outData[7:0];
  assign setup_breq_s = i_outData[15:8];
  assign setup_wval_s = i_outData[31:16];
  assign setup_wlen_s = i_outData[63:48];
  assign accept_s     = i_txnValid && txn_ready_q;
  assign sent_s       = 16'(in_nbytes_q);
  assign pkt_len_s    = (remaining_a < MAX_PKT_W) ? remaining_a : MAX_PKT_W;
  assign unused_s     = ^{i_outData, wvalue_q, src_cfg_q};

  usb_desc_rom #(
    .MAX_PKT      (MAX_PKT),
    .DEV_DESC_LEN (DEV_DESC_LEN),
    .CFG_DESC_LEN (CFG_DESC_LEN)
  ) u_desc_rom (
    .i_descType (desc_type_q),
    .i_offset   (offset_a),
    .o_data     (rom_data_s)
  );

  always_comb begin
    case (setup_wval_s[15:8])
      DESC_DEVICE: desc_len_s = 16'(DEV_DESC_LEN);
      DESC_CONFIG: desc_len_s = 16'(CFG_DESC_LEN);
      default:     desc_len_s = 16'd0;
    endcase
  end

  // Host acknowledgement of the previous IN; runs before the token so both can share a cycle.
  always_comb begin
    state_a     = state_q;
    offset_a    = offset_q;
    remaining_a = remaining_q;
    last_ack_a  = last_in_ack_q;
    dev_addr_d  = dev_addr_q;
`ifdef USB_CTRL_SETCONFIG_EN
    cfg_d       = cfg_q;
`endif
    if (i_inAck && last_in_ack_q) begin
      last_ack_a = 1'b0;
      case (state_q)
        ST_DATA_IN: begin
          offset_a    = offset_q + sent_s;
          remaining_a = remaining_q - sent_s;
          // A full final packet short of wLength needs a ZLP to terminate the data stage.
          if (remaining_a != 16'd0) begin
            state_a = ST_DATA_IN;
          end else if (sent_s == MAX_PKT_W && total_q < wlength_q) begin
            state_a = ST_DATA_IN;
          end else begin
            state_a = ST_STATUS_OUT;
          end
        end
        ST_STATUS_IN: begin
          if (act_q == ACT_SET_ADDR) begin
            dev_addr_d = wvalue_q[6:0];
`ifdef USB_CTRL_SETCONFIG_EN
          end else if (act_q == ACT_SET_CFG) begin
            cfg_d = wvalue_q;
`endif
          end else begin
            dev_addr_d = dev_addr_q;
          end
          state_a = ST_IDLE;
        end
        default: state_a = state_q;
      endcase
    end else begin
      last_ack_a = last_in_ack_q;
    end
  end

  always_comb begin
    state_d       = state_a;
    offset_d      = offset_a;
    remaining_d   = remaining_a;
    total_d       = total_q;
    wlength_d     = wlength_q;
    desc_type_d   = desc_type_q;
    wvalue_d      = wvalue_q;
    src_cfg_d     = src_cfg_q;
    act_d         = act_q;
    last_in_ack_d = last_ack_a;
    txn_ready_d   = ~accept_s;
    rsp_valid_d   = accept_s;
    rsp_hsk_d     = rsp_hsk_q;
    in_data_d     = in_data_q;
    in_nbytes_d   = in_nbytes_q;
    if (accept_s) begin
      rsp_hsk_d     = HSK_NAK;
      in_data_d     = '0;
      in_nbytes_d   = '0;
      last_in_ack_d = 1'b0;
      case (i_txnType)
        TXN_SETUP: begin
          rsp_hsk_d   = HSK_ACK;
          offset_d    = 16'd0;
          remaining_d = 16'd0;
          total_d     = 16'd0;
          wlength_d   = setup_wlen_s;
          wvalue_d    = setup_wval_s[7:0];
          desc_type_d = setup_wval_s[15:8];
          src_cfg_d   = 1'b0;
          act_d       = ACT_NONE;
          state_d     = ST_STALLED;
          if (i_outData_nBytes != NBW'(8)) begin
            state_d = ST_STALLED;
          end else begin
            case (setup_breq_s)
              REQ_GET_DESCRIPTOR: begin
                if (setup_bm_s == RT_DEV_TO_HOST && desc_len_s != 16'd0) begin
                  state_d     = ST_DATA_IN;
                  remaining_d = min_u16(setup_wlen_s, desc_len_s);
                  total_d     = min_u16(setup_wlen_s, desc_len_s);
                end else begin
                  state_d = ST_STALLED;
                end
              end
              REQ_SET_ADDRESS: begin
                if (setup_bm_s == RT_HOST_TO_DEV) begin
                  state_d = ST_STATUS_IN;
                  act_d   = ACT_SET_ADDR;
                end else begin
                  state_d = ST_STALLED;
                end
              end
`ifdef USB_CTRL_SETCONFIG_EN
              REQ_SET_CONFIGURATION: begin
                if (setup_bm_s == RT_HOST_TO_DEV) begin
                  state_d = ST_STATUS_IN;
                  act_d   = ACT_SET_CFG;
                end else begin
                  state_d = ST_STALLED;
                end
              end
              REQ_GET_CONFIGURATION: begin
                if (setup_bm_s == RT_DEV_TO_HOST) begin
                  state_d     = ST_DATA_IN;
                  src_cfg_d   = 1'b1;
                  remaining_d = min_u16(setup_wlen_s, 16'd1);
                  total_d     = min_u16(setup_wlen_s, 16'd1);
                end else begin
                  state_d = ST_STALLED;
                end
              end
`endif
              default: state_d = ST_STALLED;
            endcase
          end
        end
        TXN_IN: begin
          case (state_a)
            ST_DATA_IN: begin
              rsp_hsk_d     = HSK_ACK;
`ifdef USB_CTRL_SETCONFIG_EN
              in_data_d     = src_cfg_q ? {{(8*MAX_PKT-8){1'b0}}, cfg_q} : rom_data_s;
`else
              in_data_d     = rom_data_s;
`endif
              in_nbytes_d   = pkt_len_s[NBW-1:0];
              last_in_ack_d = 1'b1;
            end
            ST_STATUS_IN: begin
              rsp_hsk_d     = HSK_ACK;
              last_in_ack_d = 1'b1;
            end
            ST_STALLED: rsp_hsk_d = HSK_STALL;
            default:    rsp_hsk_d = HSK_NAK;
          endcase
        end
        TXN_OUT: begin
          case (state_a)
            ST_STATUS_OUT: begin
              if (i_outData_nBytes == NBW'(0)) begin
                rsp_hsk_d = HSK_ACK;
                state_d   = ST_IDLE;
              end else begin
                rsp_hsk_d = HSK_STALL;
                state_d   = ST_STALLED;
              end
            end
            ST_STALLED: rsp_hsk_d = HSK_STALL;
            default:    rsp_hsk_d = HSK_NAK;
          endcase
        end
        default: rsp_hsk_d = HSK_NAK;
      endcase
    end else begin
      rsp_hsk_d = rsp_hsk_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      act_q         <= ACT_NONE;
      offset_q      <= 16'd0;
      remaining_q   <= 16'd0;
      total_q       <= 16'd0;
      wlength_q     <= 16'd0;
      desc_type_q   <= 8'd0;
      wvalue_q      <= 8'd0;
      src_cfg_q     <= 1'b0;
      last_in_ack_q <= 1'b0;
      dev_addr_q    <= 7'd0;
      txn_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_hsk_q     <= HSK_ACK;
      in_data_q     <= '0;
      in_nbytes_q   <= '0;
`ifdef USB_CTRL_SETCONFIG_EN
      cfg_q         <= 8'd0;
`endif
    end else begin
      state_q       <= state_d;
      act_q         <= act_d;
      offset_q      <= offset_d;
      remaining_q   <= remaining_d;
      total_q       <= total_d;
      wlength_q     <= wlength_d;
      desc_type_q   <= desc_type_d;
      wvalue_q      <= wvalue_d;
      src_cfg_q     <= src_cfg_d;
      last_in_ack_q <= last_in_ack_d;
      dev_addr_q    <= dev_addr_d;
      txn_ready_q   <= txn_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_hsk_q     <= rsp_hsk_d;
      in_data_q     <= in_data_d;
      in_nbytes_q   <= in_nbytes_d;
`ifdef USB_CTRL_SETCONFIG_EN
      cfg_q         <= cfg_d;
`endif
    end
  end

  assign o_txnReady      = txn_ready_q;
  assign o_rspValid      = rsp_valid_q;
  assign o_rspHsk        = rsp_hsk_q;
  assign o_inData        = in_data_q;
  assign o_inData_nBytes = in_nbytes_q;
  assign o_devAddr       = dev_addr_q;

endmodule

// File: tb/tb_usb_ctrl_ep0_responder.sv
// Scoreboard bench for usb_ctrl_ep0_responder: expected responses queued per token, checked on o_rspValid.
module tb_usb_ctrl_ep0_responder;
  import usb_ctrl_ep0_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_txnValid = 1'b0;
  logic        o_txnReady;
  logic [2:0]  i_txnType = 3'b000;
  logic [63:0] i_outData = 64'd0;
  logic [3:0]  i_outData_nBytes = 4'd0;
  logic        o_rspValid;
  logic [1:0]  o_rspHsk;
  logic [63:0] o_inData;
  logic [3:0]  o_inData_nBytes;
  logic        i_inAck = 1'b0;
  logic [6:0]  o_devAddr;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [1:0]  hsk;
    logic [3:0]  n;
    logic [63:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] dev_rom [0:17] = '{8'h12, 8'h01, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h08, 8'h34,
                                 8'h12, 8'h78, 8'h56, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h01};
  logic [7:0] cfg_rom [0:31] = '{8'h09, 8'h02, 8'h20, 8'h00, 8'h01, 8'h01, 8'h00, 8'h80, 8'h32,
                                 8'h09, 8'h04, 8'h00, 8'h00, 8'h02, 8'hff, 8'h00, 8'h00, 8'h00,
                                 8'h07, 8'h05, 8'h81, 8'h02, 8'h40, 8'h00, 8'h00,
                                 8'h07, 8'h05, 8'h02, 8'h02, 8'h40, 8'h00, 8'h00};

  usb_ctrl_ep0_responder dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_txnValid       (i_txnValid),
    .o_txnReady       (o_txnReady),
    .i_txnType        (i_txnType),
    .i_outData        (i_outData),
    .i_outData_nBytes (i_outData_nBytes),
    .o_rspValid       (o_rspValid),
    .o_rspHsk         (o_rspHsk),
    .o_inData         (o_inData),
    .o_inData_nBytes  (o_inData_nBytes),
    .i_inAck          (i_inAck),
    .o_devAddr        (o_devAddr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] byte_mask(input logic [3:0] n);
    logic [63:0] m;
    m = 64'd0;
    for (int i = 0; i < 8; i++) if (i < int'(n)) m[8*i +: 8] = 8'hff;
    return m;
  endfunction

  function automatic logic [63:0] pkt(input bit is_cfg, input int off, input int n);
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = is_cfg ? cfg_rom[off + i] : dev_rom[off + i];
    return r;
  endfunction

  always @(negedge clk) begin
    if (o_rspValid) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_rsp", 64'(exp_q.size()), 64'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq({e.tag, "_hsk"}, 64'(o_rspHsk), 64'(e.hsk));
        check_eq({e.tag, "_nbytes"}, 64'(o_inData_nBytes), 64'(e.n));
        check_eq({e.tag, "_data"}, o_inData & byte_mask(e.n), e.data & byte_mask(e.n));
      end
    end
  end

  task automatic tok(input string tag, input logic [2:0] typ, input logic [63:0] d, input logic [3:0] nb,
                     input logic [1:0] h, input logic [3:0] en, input logic [63:0] ed);
    exp_t e;
    e.tag = tag; e.hsk = h; e.n = en; e.data = ed;
    exp_q.push_back(e);
    @(negedge clk);
    i_txnValid = 1'b1; i_txnType = typ; i_outData = d; i_outData_nBytes = nb;
    @(posedge clk);
    #1;
    i_txnValid = 1'b0;
    check_eq({tag, "_ready_low"}, 64'(o_txnReady), 64'd0);
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(posedge clk);
    check_eq({tag, "_rsp_seen"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    #1;
    check_eq({tag, "_ready_high"}, 64'(o_txnReady), 64'd1);
  endtask

  task automatic setup_tok(input string tag, input logic [63:0] d);
    tok(tag, TXN_SETUP, d, 4'd8, HSK_ACK, 4'd0, 64'd0);
  endtask

  task automatic in_tok(input string tag, input logic [1:0] h, input logic [3:0] n, input logic [63:0] d);
    tok(tag, TXN_IN, 64'd0, 4'd0, h, n, d);
  endtask

  task automatic out_tok(input string tag, input logic [3:0] nb, input logic [1:0] h);
    tok(tag, TXN_OUT, 64'd0, nb, h, 4'd0, 64'd0);
  endtask

  task automatic in_ack();
    @(negedge clk);
    i_inAck = 1'b1;
    @(posedge clk);
    #1;
    i_inAck = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_devaddr", 64'(o_devAddr), 64'd0);
    check_eq("rst_rspvalid", 64'(o_rspValid), 64'd0);
    check_eq("rst_indata", o_inData, 64'd0);
    check_eq("rst_nbytes", 64'(o_inData_nBytes), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", 64'(o_txnReady), 64'd1);

    in_tok("idle_in", HSK_NAK, 4'd0, 64'd0);
    out_tok("idle_out", 4'd0, HSK_NAK);

    // Device descriptor, wLength 18, with one unacknowledged IN resent.
    setup_tok("dev_setup", 64'h0012_0000_0100_0680);
    in_tok("dev_in0", HSK_ACK, 4'd8, pkt(1'b0, 0, 8));
    in_tok("dev_in0_resend", HSK_ACK, 4'd8, pkt(1'b0, 0, 8));
    in_ack();
    in_tok("dev_in1", HSK_ACK, 4'd8, pkt(1'b0, 8, 8));
    in_ack();
    in_tok("dev_in2", HSK_ACK, 4'd2, pkt(1'b0, 16, 2));
    in_ack();
    in_tok("dev_in3_nak", HSK_NAK, 4'd0, 64'd0);
    out_tok("dev_status", 4'd0, HSK_ACK);
    in_tok("dev_idle_in", HSK_NAK, 4'd0, 64'd0);

    // Configuration descriptor, wLength 0xffff: four full packets then a ZLP.
    setup_tok("cfg_setup", 64'hffff_0000_0200_0680);
    for (int p = 0; p < 4; p++) begin
      in_tok($sformatf("cfg_in%0d", p), HSK_ACK, 4'd8, pkt(1'b1, 8 * p, 8));
      in_ack();
    end
    in_tok("cfg_zlp", HSK_ACK, 4'd0, 64'd0);
    in_ack();
    in_tok("cfg_after_zlp", HSK_NAK, 4'd0, 64'd0);
    out_tok("cfg_status", 4'd0, HSK_ACK);

    // wLength exactly a packet multiple: no ZLP.
    setup_tok("cfg16_setup", 64'h0010_0000_0200_0680);
    in_tok("cfg16_in0", HSK_ACK, 4'd8, pkt(1'b1, 0, 8));
    in_ack();
    in_tok("cfg16_in1", HSK_ACK, 4'd8, pkt(1'b1, 8, 8));
    in_ack();
    in_tok("cfg16_no_zlp", HSK_NAK, 4'd0, 64'd0);
    out_tok("cfg16_status", 4'd0, HSK_ACK);

    // String descriptor is unsupported.
    setup_tok("str_setup", 64'h00ff_0000_0300_0680);
    in_tok("str_in", HSK_STALL, 4'd0, 64'd0);
    out_tok("str_out", 4'd0, HSK_STALL);

    // SET_ADDRESS 55; a stray ack before the status IN must be ignored.
    setup_tok("addr_setup", 64'h0000_0000_0037_0500);
    in_ack();
    check_eq("addr_stray_ack", 64'(o_devAddr), 64'd0);
    in_tok("addr_status", HSK_ACK, 4'd0, 64'd0);
    check_eq("addr_before_ack", 64'(o_devAddr), 64'd0);
    in_ack();
    check_eq("addr_after_ack", 64'(o_devAddr), 64'h37);
    in_tok("addr_idle_in", HSK_NAK, 4'd0, 64'd0);

    // SETUP mid-transfer aborts and serves the new request.
    setup_tok("abort_setup", 64'h0012_0000_0100_0680);
    in_tok("abort_in0", HSK_ACK, 4'd8, pkt(1'b0, 0, 8));
    in_ack();
    setup_tok("abort_new_setup", 64'h0009_0000_0200_0680);
    in_tok("abort_new_in0", HSK_ACK, 4'd8, pkt(1'b1, 0, 8));
    in_ack();
    in_tok("abort_new_in1", HSK_ACK, 4'd1, pkt(1'b1, 8, 1));
    in_ack();
    in_tok("abort_new_done", HSK_NAK, 4'd0, 64'd0);

    // Short SETUP stalls.
    tok("short_setup", TXN_SETUP, 64'h0012_0000_0100_0680, 4'd4, HSK_ACK, 4'd0, 64'd0);
    in_tok("short_in", HSK_STALL, 4'd0, 64'd0);

`ifdef USB_CTRL_SETCONFIG_EN
    setup_tok("setcfg_setup", 64'h0000_0000_0005_0900);
    in_tok("setcfg_status", HSK_ACK, 4'd0, 64'd0);
    in_ack();
    setup_tok("getcfg_setup", 64'h0001_0000_0000_0880);
    in_tok("getcfg_in", HSK_ACK, 4'd1, 64'h05);
    in_ack();
    out_tok("getcfg_status", 4'd0, HSK_ACK);
`else
    setup_tok("setcfg_setup", 64'h0000_0000_0005_0900);
    in_tok("setcfg_stall", HSK_STALL, 4'd0, 64'd0);
    setup_tok("getcfg_setup", 64'h0001_0000_0000_0880);
    in_tok("getcfg_stall", HSK_STALL, 4'd0, 64'd0);
`endif

    // Reset mid-DATA_IN discards context and address.
    setup_tok("rst_setup", 64'h0012_0000_0100_0680);
    in_tok("rst_in0", HSK_ACK, 4'd8, pkt(1'b0, 0, 8));
    in_ack();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_devaddr", 64'(o_devAddr), 64'd0);
    check_eq("midrst_nbytes", 64'(o_inData_nBytes), 64'd0);
    rst = 1'b0;
    in_tok("midrst_idle_in", HSK_NAK, 4'd0, 64'd0);
    out_tok("midrst_idle_out", 4'd0, HSK_NAK);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
